// File: rtl/id_auth_fsm.sv
// id_auth_fsm -- player login checker.
// Collects a DIGITS-long user ID, one digit per b_id pulse, then walks an
// external ID ROM (MAX_ENTRIES words, ROM_LAT-cycle read) looking for it.
// On a hit the ROM index becomes the internal player ID and a guest flag is
// raised for GUEST_ID. An END_ID word or the end of the table rejects the ID.
// Optional feature macro: IDCHK_LOCKOUT_EN enables the consecutive-failure
// counter and a timed LOCKOUT state (MAX_FAILS / LOCK_CYCLES parameters).
// Ports:
//   clk, rst          clock, synchronous active-high reset
//   idDigit, b_id     digit value and its single-cycle accept pulse
//   logout            ends a session (PASSED only)
//   ROM_data/ROM_addr ID ROM read port (address registered)
//   matchedID         logged in; internalPlayerID / isGuest valid with it
//   failPulse         one-cycle pulse per rejected ID
//   locked            lockout in progress (tied 0 without the feature)
//   digitCount        digits captured so far
module id_auth_fsm #(
  parameter int unsigned DIGITS      = 4,
  parameter int unsigned DIGIT_W     = 4,
  parameter int unsigned ADDR_W      = 5,
  parameter int unsigned MAX_ENTRIES = 8,
  parameter int unsigned ROM_LAT     = 2,
  parameter logic [DIGITS*DIGIT_W-1:0] GUEST_ID = {DIGITS{DIGIT_W'(1)}},
  parameter logic [DIGITS*DIGIT_W-1:0] END_ID   = '1
`ifdef IDCHK_LOCKOUT_EN
  ,
  parameter int unsigned MAX_FAILS   = 3,
  parameter int unsigned LOCK_CYCLES = 1024
`endif
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [DIGIT_W-1:0]            idDigit,
  input  logic                          b_id,
  input  logic                          logout,
  input  logic [DIGITS*DIGIT_W-1:0]     ROM_data,
  output logic [ADDR_W-1:0]             ROM_addr,
  output logic                          matchedID,
  output logic [ADDR_W-1:0]             internalPlayerID,
  output logic                          isGuest,
  output logic                          failPulse,
  output logic                          locked,
  output logic [$clog2(DIGITS+1)-1:0]   digitCount
);

  localparam int unsigned IDW = DIGITS * DIGIT_W;
  localparam int unsigned DCW = $clog2(DIGITS + 1);
  localparam int unsigned WW  = $clog2(ROM_LAT + 1);

  typedef enum logic [2:0] {
    S_ENTRY, S_FETCH, S_WAIT, S_CATCH, S_COMPARE, S_NEXT, S_PASSED
`ifdef IDCHK_LOCKOUT_EN
    , S_LOCKOUT
`endif
  } state_t;

  state_t             state_q, state_d;
  logic [IDW-1:0]     uid_q, uid_d;
  logic [IDW-1:0]     rom_word_q, rom_word_d;
  logic [ADDR_W-1:0]  index_q, index_d;
  logic [ADDR_W-1:0]  rom_addr_q, rom_addr_d;
  logic [WW-1:0]      wait_cnt_q, wait_cnt_d;
  logic [DCW-1:0]     digit_cnt_q, digit_cnt_d;
  logic               matched_q, matched_d;
  logic [ADDR_W-1:0]  pid_q, pid_d;
  logic               guest_q, guest_d;
  logic               fail_pulse_q, fail_pulse_d;

  logic digit_done, rom_end, rom_hit, last_idx, reject, clear_all;

  assign digit_done = b_id && (digit_cnt_q == DCW'(DIGITS - 1));
  assign rom_end    = (rom_word_q == END_ID);
  assign rom_hit    = (rom_word_q == uid_q);
  assign last_idx   = (index_q == ADDR_W'(MAX_ENTRIES - 1));
  // END_ID is tested before the uid match, so an all-ones entry never logs in.
  assign reject     = ((state_q == S_COMPARE) && rom_end) ||
                      ((state_q == S_NEXT) && last_idx);

`ifdef IDCHK_LOCKOUT_EN
  localparam int unsigned FCW = $clog2(MAX_FAILS + 1);
  localparam int unsigned LCW = $clog2(LOCK_CYCLES + 1);
  logic [FCW-1:0] fail_cnt_q, fail_cnt_d;
  logic [LCW-1:0] lock_cnt_q, lock_cnt_d;
  logic           locked_q, locked_d;
  logic           lock_trip, lock_done;
  assign lock_trip = (fail_cnt_q + FCW'(1)) == FCW'(MAX_FAILS);
  assign lock_done = (lock_cnt_q == '0);
  assign locked    = locked_q;
`else
  assign locked    = 1'b0;
`endif

  // State register
  always_ff @(posedge clk) begin
    if (rst) state_q <= S_ENTRY;
    else     state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_ENTRY:   if (digit_done) state_d = S_FETCH;
      S_FETCH:   state_d = S_WAIT;
      S_WAIT:    if (wait_cnt_q == '0) state_d = S_CATCH;
      S_CATCH:   state_d = S_COMPARE;
      S_COMPARE: begin
        if (rom_end)      state_d = S_ENTRY;
        else if (rom_hit) state_d = S_PASSED;
        else              state_d = S_NEXT;
      end
      S_NEXT:    state_d = last_idx ? S_ENTRY : S_FETCH;
      S_PASSED:  if (logout) state_d = S_ENTRY;
`ifdef IDCHK_LOCKOUT_EN
      S_LOCKOUT: if (lock_done) state_d = S_ENTRY;
`endif
      default:   state_d = S_ENTRY;
    endcase
`ifdef IDCHK_LOCKOUT_EN
    if (reject && lock_trip) state_d = S_LOCKOUT;
`endif
  end

  // Datapath / output next values
  always_comb begin
    uid_d        = uid_q;
    rom_word_d   = rom_word_q;
    index_d      = index_q;
    rom_addr_d   = rom_addr_q;
    wait_cnt_d   = wait_cnt_q;
    digit_cnt_d  = digit_cnt_q;
    matched_d    = matched_q;
    pid_d        = pid_q;
    guest_d      = guest_q;
    fail_pulse_d = 1'b0;
    clear_all    = 1'b0;
`ifdef IDCHK_LOCKOUT_EN
    fail_cnt_d   = fail_cnt_q;
    lock_cnt_d   = lock_cnt_q;
    locked_d     = locked_q;
`endif
    case (state_q)
      S_ENTRY: begin
        if (b_id) begin
          // First digit ends in the MSBs after DIGITS shifts.
          uid_d       = (uid_q << DIGIT_W) | IDW'(idDigit);
          digit_cnt_d = digit_done ? '0 : digit_cnt_q + DCW'(1);
        end
      end
      S_FETCH: begin
        rom_addr_d = index_q;
        wait_cnt_d = WW'(ROM_LAT - 1);
      end
      S_WAIT:    if (wait_cnt_q != '0) wait_cnt_d = wait_cnt_q - WW'(1);
      S_CATCH:   rom_word_d = ROM_data;
      S_COMPARE: begin
        if (!rom_end && rom_hit) begin
          matched_d  = 1'b1;
          pid_d      = index_q;
          guest_d    = (rom_word_q == GUEST_ID);
`ifdef IDCHK_LOCKOUT_EN
          fail_cnt_d = '0;
`endif
        end
      end
      S_NEXT:    if (!last_idx) index_d = index_q + ADDR_W'(1);
      S_PASSED: begin
        if (logout) begin
          matched_d = 1'b0;
          guest_d   = 1'b0;
          pid_d     = '0;
          index_d   = '0;
          uid_d     = '0;
        end
      end
`ifdef IDCHK_LOCKOUT_EN
      S_LOCKOUT: begin
        if (lock_done) begin
          locked_d   = 1'b0;
          fail_cnt_d = '0;
        end else begin
          lock_cnt_d = lock_cnt_q - LCW'(1);
        end
      end
`endif
      default:   clear_all = 1'b1;
    endcase

    if (reject) begin
      fail_pulse_d = 1'b1;
      index_d      = '0;
      uid_d        = '0;
`ifdef IDCHK_LOCKOUT_EN
      fail_cnt_d   = fail_cnt_q + FCW'(1);
      if (lock_trip) begin
        locked_d   = 1'b1;
        lock_cnt_d = LCW'(LOCK_CYCLES - 1);
      end
`endif
    end

    if (clear_all) begin
      uid_d       = '0;
      rom_word_d  = '0;
      index_d     = '0;
      rom_addr_d  = '0;
      wait_cnt_d  = '0;
      digit_cnt_d = '0;
      matched_d   = 1'b0;
      pid_d       = '0;
      guest_d     = 1'b0;
`ifdef IDCHK_LOCKOUT_EN
      fail_cnt_d  = '0;
      lock_cnt_d  = '0;
      locked_d    = 1'b0;
`endif
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      uid_q        <= '0;
      rom_word_q   <= '0;
      index_q      <= '0;
      rom_addr_q   <= '0;
      wait_cnt_q   <= '0;
      digit_cnt_q  <= '0;
      matched_q    <= 1'b0;
      pid_q        <= '0;
      guest_q      <= 1'b0;
      fail_pulse_q <= 1'b0;
`ifdef IDCHK_LOCKOUT_EN
      fail_cnt_q   <= '0;
      lock_cnt_q   <= '0;
      locked_q     <= 1'b0;
`endif
    end else begin
      uid_q        <= uid_d;
      rom_word_q   <= rom_word_d;
      index_q      <= index_d;
      rom_addr_q   <= rom_addr_d;
      wait_cnt_q   <= wait_cnt_d;
      digit_cnt_q  <= digit_cnt_d;
      matched_q    <= matched_d;
      pid_q        <= pid_d;
      guest_q      <= guest_d;
      fail_pulse_q <= fail_pulse_d;
`ifdef IDCHK_LOCKOUT_EN
      fail_cnt_q   <= fail_cnt_d;
      lock_cnt_q   <= lock_cnt_d;
      locked_q     <= locked_d;
`endif
    end
  end

  assign ROM_addr         = rom_addr_q;
  assign matchedID        = matched_q;
  assign internalPlayerID = pid_q;
  assign isGuest          = guest_q;
  assign failPulse        = fail_pulse_q;
  assign digitCount       = digit_cnt_q;

endmodule

// File: tb/tb_id_auth_fsm.sv
module tb_id_auth_fsm;

  localparam int L    = 2;        // ROM latency
  localparam int P    = L + 4;    // cycles spent per ROM entry
  localparam int ME   = 4;        // MAX_ENTRIES for this bench
  localparam int LOCK = 16;
  localparam int MF   = 3;
`ifdef IDCHK_LOCKOUT_EN
  localparam bit LOCK_EN = 1'b1;
`else
  localparam bit LOCK_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [3:0]  idDigit = '0;
  logic        b_id = 1'b0;
  logic        logout = 1'b0;
  logic [15:0] ROM_data;
  logic [4:0]  ROM_addr;
  logic        matchedID;
  logic [4:0]  internalPlayerID;
  logic        isGuest, failPulse, locked;
  logic [2:0]  digitCount;

  always #5 clk = ~clk;

  // Behavioural ROM: exactly L registered stages after the address.
  logic [15:0] rom  [8];
  logic [15:0] pipe [L];
  always @(posedge clk) begin
    pipe[0] <= (ROM_addr < 5'd8) ? rom[ROM_addr[2:0]] : 16'h0000;
    for (int i = 1; i < L; i++) pipe[i] <= pipe[i-1];
  end
  assign ROM_data = pipe[L-1];

  id_auth_fsm #(
    .DIGITS(4), .DIGIT_W(4), .ADDR_W(5), .MAX_ENTRIES(ME), .ROM_LAT(L)
`ifdef IDCHK_LOCKOUT_EN
    , .MAX_FAILS(MF), .LOCK_CYCLES(LOCK)
`endif
  ) dut (
    .clk(clk), .rst(rst), .idDigit(idDigit), .b_id(b_id), .logout(logout),
    .ROM_data(ROM_data), .ROM_addr(ROM_addr), .matchedID(matchedID),
    .internalPlayerID(internalPlayerID), .isGuest(isGuest),
    .failPulse(failPulse), .locked(locked), .digitCount(digitCount)
  );

  int n_checks = 0;
  int n_err    = 0;
  int fails    = 0;   // model of consecutive rejections

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference: scan table in order; sentinel wins over a match; full table
  // rejects one cycle after the last compare.
  task automatic model(input logic [15:0] id, output bit m, output int k,
                       output bit g, output int t);
    m = 1'b0; g = 1'b0; k = ME - 1; t = (ME - 1) * P + L + 4;
    for (int i = 0; i < ME; i++) begin
      if (rom[i] == 16'hFFFF) begin
        k = i; t = i * P + L + 3; break;
      end
      if (rom[i] == id) begin
        m = 1'b1; k = i; t = i * P + L + 3; g = (id == 16'h1111); break;
      end
    end
  endtask

  task automatic enter_id(input logic [15:0] id);
    for (int d = 0; d < 4; d++) begin
      idDigit = id[15 - 4*d -: 4];
      b_id    = 1'b1;
      tick();
      chk("digitCount_entry", 32'(digitCount), (d == 3) ? 0 : d + 1);
    end
    b_id = 1'b0;
  endtask

  task automatic attempt(input logic [15:0] id, input bit em, input int ek,
                         input bit eg, input int et, input bit both, input bit do_logout);
    bit trip;
    int rise, fp_t, fp_n, lk_t, lk_n, dc_bad, addr_bad, max_addr, limit;
    rise = 0; fp_t = 0; fp_n = 0; lk_t = 0; lk_n = 0; dc_bad = 0; addr_bad = 0; max_addr = 0;
    enter_id(id);
    trip  = !em && LOCK_EN && (fails + 1 == MF);
    limit = et + (trip ? LOCK + 3 : 3);
    for (int t = 1; t <= limit; t++) begin
      // b_id/logout toggled only where they must be ignored
      if (t <= et || (trip && t <= et + LOCK) || em) begin
        b_id    = 1'($urandom_range(0, 1));
        idDigit = 4'($urandom_range(0, 15));
      end else b_id = 1'b0;
      logout = (t <= et || (trip && t <= et + LOCK)) ? 1'($urandom_range(0, 1)) : 1'b0;
      tick();
      if (matchedID && rise == 0) rise = t;
      if (failPulse) begin fp_n++; if (fp_t == 0) fp_t = t; end
      if (locked) begin lk_n++; if (lk_t == 0) lk_t = t; end
      if (digitCount != 0) dc_bad++;
      if (int'(ROM_addr) > max_addr) max_addr = int'(ROM_addr);
      if (t <= et && int'(ROM_addr) != (t - 1) / P) addr_bad++;
    end
    b_id = 1'b0; logout = 1'b0;
    chk("addr_seq", addr_bad, 0);
    chk("max_addr", max_addr, ek);
    chk("digit_ignored", dc_bad, 0);
    if (em) begin
      chk("match_time", rise, et);
      chk("match_nofail", fp_n, 0);
      chk("player_id", 32'(internalPlayerID), ek);
      chk("is_guest", 32'(isGuest), 32'(eg));
      fails = 0;
    end else begin
      chk("reject_nomatch", rise, 0);
      chk("fail_time", fp_t, et);
      chk("fail_width", fp_n, 1);
      fails = trip ? 0 : fails + 1;
    end
    chk("lock_start", lk_t, trip ? et : 0);
    chk("lock_len", lk_n, trip ? LOCK : 0);
    if (em && do_logout) begin
      logout = 1'b1; b_id = both; idDigit = 4'h7;
      tick();
      logout = 1'b0; b_id = 1'b0;
      chk("logout_matched", 32'(matchedID), 0);
      chk("logout_pid", 32'(internalPlayerID), 0);
      chk("logout_guest", 32'(isGuest), 0);
      chk("logout_digits", 32'(digitCount), 0);
    end
  endtask

  task automatic do_reset(input string tag);
    rst = 1'b1; b_id = 1'b0; logout = 1'b0;
    tick();
    chk({tag, "_addr"},   32'(ROM_addr), 0);
    chk({tag, "_match"},  32'(matchedID), 0);
    chk({tag, "_pid"},    32'(internalPlayerID), 0);
    chk({tag, "_guest"},  32'(isGuest), 0);
    chk({tag, "_fail"},   32'(failPulse), 0);
    chk({tag, "_locked"}, 32'(locked), 0);
    chk({tag, "_digits"}, 32'(digitCount), 0);
    rst = 1'b0;
    fails = 0;
  endtask

  task automatic load_rom_a();
    rom[0] = 16'h1234; rom[1] = 16'h1111; rom[2] = 16'h5678; rom[3] = 16'hFFFF;
    for (int i = 4; i < 8; i++) rom[i] = 16'h9999;
  endtask

  typedef struct {
    logic [15:0] id;
    bit          m;
    int          k;
    bit          g;
    int          t;
    bit          both;
  } vec_t;
  vec_t vecs [5];

  initial begin
    bit m, g;
    int k, t;
    logic [15:0] id;

    vecs[0] = '{16'h5678, 1'b1, 2, 1'b0, 17, 1'b0};
    vecs[1] = '{16'h1111, 1'b1, 1, 1'b1, 11, 1'b1};
    vecs[2] = '{16'h1234, 1'b1, 0, 1'b0,  5, 1'b0};
    vecs[3] = '{16'h9999, 1'b0, 3, 1'b0, 23, 1'b0};
    vecs[4] = '{16'hFFFF, 1'b0, 3, 1'b0, 23, 1'b0};

    load_rom_a();
    tick(); tick();
    do_reset("rst0");

    foreach (vecs[i])
      attempt(vecs[i].id, vecs[i].m, vecs[i].k, vecs[i].g, vecs[i].t, vecs[i].both, 1'b1);

    // Table without sentinel: stops at MAX_ENTRIES-1; entries beyond are never read.
    rom[0] = 16'h1234; rom[1] = 16'h2222; rom[2] = 16'h3333; rom[3] = 16'h4444;
    for (int i = 4; i < 8; i++) rom[i] = 16'hABCD;
    attempt(16'hABCD, 1'b0, 3, 1'b0, 3 * P + L + 4, 1'b0, 1'b1);
    load_rom_a();
    attempt(16'h1234, 1'b1, 0, 1'b0, 5, 1'b0, 1'b1);

    // Partial digit entry then reset
    idDigit = 4'h5; b_id = 1'b1; tick(); tick(); b_id = 1'b0;
    chk("partial_digits", 32'(digitCount), 2);
    do_reset("rst_digits");

    // Reset mid-WAIT on index 2
    enter_id(16'h5678);
    for (int i = 0; i < 2 * P + 2; i++) tick();
    chk("wait_addr", 32'(ROM_addr), 2);
    do_reset("rst_wait");
    attempt(16'h5678, 1'b1, 2, 1'b0, 17, 1'b0, 1'b0);
    do_reset("rst_passed");

    // Third consecutive failure, reset during lockout (or plain ENTRY without it)
    attempt(16'h9999, 1'b0, 3, 1'b0, 23, 1'b0, 1'b1);
    attempt(16'h4321, 1'b0, 3, 1'b0, 23, 1'b0, 1'b1);
    enter_id(16'h0000);
    for (int i = 0; i < 23; i++) tick();
    chk("third_fail", 32'(failPulse), 1);
    for (int i = 0; i < 3; i++) tick();
    chk("third_locked", 32'(locked), 32'(LOCK_EN));
    do_reset("rst_lock");
    attempt(16'h1111, 1'b1, 1, 1'b1, 11, 1'b0, 1'b1);

    // Randomised tables and IDs against the model
    for (int n = 0; n < 25; n++) begin
      for (int i = 0; i < 8; i++) begin
        case ($urandom_range(0, 9))
          0:       rom[i] = 16'hFFFF;
          1:       rom[i] = 16'h1111;
          default: rom[i] = 16'($urandom);
        endcase
      end
      if ($urandom_range(0, 1) == 1) id = rom[$urandom_range(0, ME - 1)];
      else                           id = 16'($urandom);
      model(id, m, k, g, t);
      attempt(id, m, k, g, t, 1'($urandom_range(0, 1)), 1'b1);
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_err);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

endmodule
